// File: rtl/servo_pkg.sv
// Shared constants, counter widths and FSM state type for the servo pulse
// decoder and the matching PWM generator.
`timescale 1ns/1ps
package servo_pkg;

   localparam int FRAME_TICKS_DEF   = 1000;
   localparam int MIN_PULSE_DEF     = 25;
   localparam int MAX_PULSE_DEF     = 125;
   localparam int TIMEOUT_TICKS_DEF = 2000;

   localparam int HIGH_W  = 10;
   localparam int FRAME_W = 11;

   localparam logic [HIGH_W-1:0]  HIGH_MAX  = '1;
   localparam logic [FRAME_W-1:0] FRAME_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } servo_state_t;

   function automatic logic [HIGH_W-1:0] sat_inc_high(input logic [HIGH_W-1:0] v);
      return (v == HIGH_MAX) ? v : v + 1'b1;
   endfunction

   function automatic logic [FRAME_W-1:0] sat_inc_frame(input logic [FRAME_W-1:0] v);
      return (v == FRAME_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/servo_pulse_decoder_if.sv
// Servo input and measurement results. valid is a one-cycle strobe with no
// back-pressure: pulse_width/frame_len/range_err are meaningful while valid=1.
`timescale 1ns/1ps
interface servo_pulse_decoder_if;
   import servo_pkg::*;

   logic                servo_in;
   logic [HIGH_W-1:0]   pulse_width;
   logic [FRAME_W-1:0]  frame_len;
   logic                valid;
   logic                range_err;
   logic                timeout;
   servo_state_t        dbg_state;

   modport master (
      output servo_in,
      input  pulse_width, frame_len, valid, range_err, timeout, dbg_state
   );

   modport slave (
      input  servo_in,
      output pulse_width, frame_len, valid, range_err, timeout, dbg_state
   );
endinterface

// File: rtl/servo_pulse_decoder_sync_edge_detect.sv
// Two-flop synchronizer followed by a registered rise/fall detector.
// Rises are suppressed until the synchronized input has been seen low once.
`timescale 1ns/1ps
module sync_edge_detect (
   input  logic clk,
   input  logic resetn,
   input  logic i_din,
   output logic o_rise,
   output logic o_fall
);

   logic       r_sync1;
   logic       r_sync2;
   logic       r_prev;
   logic       r_rise;
   logic       r_fall;
   logic       r_armed;
   logic [1:0] r_fill;

   // r_fill marks when r_sync2 reflects the pin rather than reset values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_armed <= 1'b0;
         r_fill  <= 2'b00;
      end else begin
         r_sync1 <= i_din;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_fill  <= {r_fill[0], 1'b1};
         if (r_fill[1] && !r_sync2)
            r_armed <= 1'b1;
         r_rise  <= r_armed & r_sync2 & ~r_prev;
         r_fall  <= r_prev & ~r_sync2;
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures servo PWM high time and rising-edge period, publishing one result
// per complete frame and flagging out-of-range pulses and loss of signal.
`timescale 1ns/1ps
module servo_pulse_decoder
   import servo_pkg::*;
#(
   parameter int FRAME_TICKS   = FRAME_TICKS_DEF,
   parameter int MIN_PULSE     = MIN_PULSE_DEF,
   parameter int MAX_PULSE     = MAX_PULSE_DEF,
   parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
   input logic                   clk,
   input logic                   resetn,
   servo_pulse_decoder_if.slave  io_bus
);

   // A timeout no longer than one nominal frame would drop every frame.
   localparam int TO_EFF = (TIMEOUT_TICKS > FRAME_TICKS) ? TIMEOUT_TICKS : 2 * FRAME_TICKS;
   localparam int TO_CLP = (TO_EFF > (1 << FRAME_W) - 1) ? (1 << FRAME_W) - 1 : TO_EFF;
   localparam logic [FRAME_W-1:0] TO_LIM = FRAME_W'(TO_CLP);
   localparam logic [HIGH_W-1:0]  MIN_L  = HIGH_W'(MIN_PULSE);
   localparam logic [HIGH_W-1:0]  MAX_L  = HIGH_W'(MAX_PULSE);

   logic w_rise;
   logic w_fall;
   logic w_to_hit;

   servo_state_t        r_state,       w_state_nxt;
   logic [HIGH_W-1:0]   r_high_cnt,    w_high_nxt;
   logic [HIGH_W-1:0]   r_hold,        w_hold_nxt;
   logic [HIGH_W-1:0]   r_pulse_width, w_pw_nxt;
   logic [FRAME_W-1:0]  r_frame_cnt,   w_frame_nxt;
   logic [FRAME_W-1:0]  r_frame_len,   w_fl_nxt;
   logic                r_valid,       w_valid_nxt;
   logic                r_range_err,   w_re_nxt;
   logic                r_timeout,     w_to_nxt;

   sync_edge_detect u_sync (
      .clk    (clk),
      .resetn (resetn),
      .i_din  (io_bus.servo_in),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   assign w_to_hit = (r_frame_cnt >= TO_LIM);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= ST_IDLE;
         r_high_cnt    <= '0;
         r_hold        <= '0;
         r_pulse_width <= '0;
         r_frame_cnt   <= '0;
         r_frame_len   <= '0;
         r_valid       <= 1'b0;
         r_range_err   <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_high_cnt    <= w_high_nxt;
         r_hold        <= w_hold_nxt;
         r_pulse_width <= w_pw_nxt;
         r_frame_cnt   <= w_frame_nxt;
         r_frame_len   <= w_fl_nxt;
         r_valid       <= w_valid_nxt;
         r_range_err   <= w_re_nxt;
         r_timeout     <= w_to_nxt;
      end
   end

   // Timeout is tested before the rise so a coincident rise is dropped.
   always_comb begin
      w_state_nxt = r_state;
      w_high_nxt  = r_high_cnt;
      w_hold_nxt  = r_hold;
      w_pw_nxt    = r_pulse_width;
      w_frame_nxt = r_frame_cnt;
      w_fl_nxt    = r_frame_len;
      w_valid_nxt = 1'b0;
      w_re_nxt    = r_range_err;
      w_to_nxt    = r_timeout;
      case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_state_nxt = ST_HIGH;
               w_high_nxt  = HIGH_W'(1);
               w_frame_nxt = FRAME_W'(1);
            end
         end
         ST_HIGH: begin
            if (w_to_hit) begin
               w_state_nxt = ST_IDLE;
               w_to_nxt    = 1'b1;
            end else begin
               w_high_nxt  = sat_inc_high(r_high_cnt);
               w_frame_nxt = sat_inc_frame(r_frame_cnt);
               if (w_fall) begin
                  w_hold_nxt  = r_high_cnt;
                  w_state_nxt = ST_LOW;
               end
            end
         end
         ST_LOW: begin
            if (w_to_hit) begin
               w_state_nxt = ST_IDLE;
               w_to_nxt    = 1'b1;
            end else if (w_rise) begin
               w_pw_nxt    = r_hold;
               w_fl_nxt    = r_frame_cnt;
               w_re_nxt    = (r_hold < MIN_L) || (r_hold > MAX_L);
               w_valid_nxt = 1'b1;
               w_to_nxt    = 1'b0;
               w_high_nxt  = HIGH_W'(1);
               w_frame_nxt = FRAME_W'(1);
               w_state_nxt = ST_HIGH;
            end else begin
               w_frame_nxt = sat_inc_frame(r_frame_cnt);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign io_bus.pulse_width = r_pulse_width;
   assign io_bus.frame_len   = r_frame_len;
   assign io_bus.valid       = r_valid;
   assign io_bus.range_err   = r_range_err;
   assign io_bus.timeout     = r_timeout;
   assign io_bus.dbg_state   = r_state;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed and randomized frames for servo_pulse_decoder, checked against a
// rise-time based model of what each completed frame must publish.
`timescale 1ns/1ps
module tb_servo_pulse_decoder;
   import servo_pkg::*;

   localparam int TO_T  = 2000;
   localparam int MIN_P = 25;
   localparam int MAX_P = 125;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic resetn;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   servo_pulse_decoder_if bus();

   servo_pulse_decoder #(
      .FRAME_TICKS   (1000),
      .MIN_PULSE     (MIN_P),
      .MAX_PULSE     (MAX_P),
      .TIMEOUT_TICKS (TO_T)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .io_bus (bus)
   );

   // ---------------- counters / scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;
   int n_valid = 0;

   logic [21:0] exp_q[$];      // {range_err, frame_len, pulse_width}
   int          exp_rise_q[$]; // cycle of the servo_in rise that completes the frame

   bit m_armed     = 1'b0;
   int m_last_rise = 0;
   int m_high      = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [21:0] model_pack(input int high, input int period);
      int   w;
      logic re;
      w  = (high > 1023) ? 1023 : high;
      re = (w < MIN_P) || (w > MAX_P);
      return {re, 11'(period), 10'(w)};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_rise(input int high);
      int p;
      @(negedge clk);
      p = cyc - m_last_rise;
      if (m_armed && p < TO_T) begin
         exp_q.push_back(model_pack(m_high, p));
         exp_rise_q.push_back(cyc);
      end
      m_armed     = 1'b1;
      m_last_rise = cyc;
      m_high      = high;
      bus.servo_in = 1'b1;
   endtask

   task automatic start_frame(input int high);
      do_rise(high);
      repeat (high) @(negedge clk);
      bus.servo_in = 1'b0;
   endtask

   task automatic frame(input int high, input int period);
      start_frame(high);
      repeat (period - high - 1) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pw"},    bus.pulse_width, 0);
      chk({tag, "_fl"},    bus.frame_len,   0);
      chk({tag, "_valid"}, bus.valid,       0);
      chk({tag, "_re"},    bus.range_err,   0);
      chk({tag, "_to"},    bus.timeout,     0);
      chk({tag, "_state"}, bus.dbg_state,   ST_IDLE);
   endtask

   // ---------------- monitor ----------------
   logic        prev_valid = 1'b0;
   logic [21:0] mon_e;
   int          mon_rc;

   always @(negedge clk) begin
      if (!resetn) begin
         prev_valid = 1'b0;
      end else begin
         if (prev_valid)
            chk("valid_width", bus.valid, 0);
         if (bus.valid) begin
            n_valid++;
            chk("valid_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               mon_e  = exp_q.pop_front();
               mon_rc = exp_rise_q.pop_front();
               chk("pulse_width", bus.pulse_width, mon_e[9:0]);
               chk("frame_len",   bus.frame_len,   mon_e[20:10]);
               chk("range_err",   bus.range_err,   mon_e[21]);
               chk("latency",     cyc - mon_rc,    4);
               chk("timeout_clr", bus.timeout,     0);
            end
         end else if (exp_rise_q.size() != 0 && cyc > exp_rise_q[0] + 4) begin
            chk("valid_missing", cyc - exp_rise_q[0], 4);
            void'(exp_q.pop_front());
            void'(exp_rise_q.pop_front());
         end
         prev_valid = bus.valid;
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int v0;
      int h;
      int p;
      resetn       = 1'b0;
      bus.servo_in = 1'b0;
      idle(5);
      chk_all_zero("reset");
      resetn = 1'b1;
      idle(10);

      // Three nominal frames: two publishes of 50/1000
      v0 = n_valid;
      frame(50, 1000);
      frame(50, 1000);
      frame(50, 1000);
      chk("nominal_count", n_valid - v0, 2);
      chk("nominal_pw", bus.pulse_width, 50);
      chk("nominal_fl", bus.frame_len, 1000);
      chk("nominal_re", bus.range_err, 0);

      // Range boundaries
      frame(20, 1000);
      frame(130, 1000);
      chk("short_pw", bus.pulse_width, 20);
      chk("short_re", bus.range_err, 1);
      frame(75, 1000);
      chk("long_pw", bus.pulse_width, 130);
      chk("long_re", bus.range_err, 1);
      frame(50, 1000);
      chk("mid_pw", bus.pulse_width, 75);
      chk("mid_re", bus.range_err, 0);

      // Loss of signal while low
      start_frame(50);
      idle(1945);
      chk("to_before", bus.timeout, 0);
      idle(20);
      chk("to_after", bus.timeout, 1);
      chk("to_state", bus.dbg_state, ST_IDLE);
      chk("to_hold_pw", bus.pulse_width, 50);
      chk("to_hold_fl", bus.frame_len, 1000);
      idle(200);
      frame(50, 1000);
      chk("to_still_set", bus.timeout, 1);
      chk("to_hold_pw2", bus.pulse_width, 50);
      frame(50, 1000);
      chk("to_cleared", bus.timeout, 0);

      // Glitch and high-counter saturation
      frame(1, 1000);
      frame(1100, 1500);
      chk("glitch_pw", bus.pulse_width, 1);
      chk("glitch_re", bus.range_err, 1);
      frame(50, 1000);
      chk("sat_pw", bus.pulse_width, 1023);
      chk("sat_fl", bus.frame_len, 1500);
      chk("sat_re", bus.range_err, 1);

      // Randomized frames
      for (int i = 0; i < 8; i++) begin
         h = $urandom_range(140, 1);
         p = $urandom_range(1500, h + 10);
         frame(h, p);
      end
      frame(50, 1000);

      // Stuck high
      start_frame(2500);
      chk("stuck_to", bus.timeout, 1);
      chk("stuck_state", bus.dbg_state, ST_IDLE);
      idle(100);

      // Reset in the middle of a high phase, released with input high
      frame(50, 1000);
      do_rise(600);
      idle(200);
      chk("pre_rst_state", bus.dbg_state, ST_HIGH);
      resetn  = 1'b0;
      m_armed = 1'b0;
      exp_q.delete();
      exp_rise_q.delete();
      idle(3);
      chk_all_zero("mid_rst");
      resetn = 1'b1;
      idle(50);
      chk_all_zero("rel_high");
      bus.servo_in = 1'b0;
      idle(20);
      v0 = n_valid;
      frame(50, 1000);
      frame(50, 1000);
      frame(60, 1000);
      chk("post_rst_count", n_valid - v0, 2);
      chk("post_rst_pw", bus.pulse_width, 50);
      chk("post_rst_fl", bus.frame_len, 1000);

      idle(10);
      chk("drain", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/servo_pulse_decoder.md
SERVO_PULSE_DECODER -- requirements
Module: servo_pulse_decoder

Interface
REQ-001 Parameter FRAME_TICKS, default 1000: nominal frame length in clk ticks (20 ms at 50 kHz).
REQ-002 Parameter MIN_PULSE, default 25: shortest legal high time in ticks (0.5 ms).
REQ-003 Parameter MAX_PULSE, default 125: longest legal high time in ticks (2.5 ms).
REQ-004 Parameter TIMEOUT_TICKS, default 2000: ticks with no rising edge before loss-of-signal.
REQ-005 clk  input  1  50 kHz system clock; all logic on its rising edge.
REQ-006 resetn  input  1  reset, asynchronous, active-low.
REQ-007 servo_in  input  1  asynchronous servo PWM input, active-high pulse.
REQ-008 pulse_width  output  10  high time of last complete frame in ticks.
REQ-009 frame_len  output  11  rising-edge-to-rising-edge period of last complete frame in ticks.
REQ-010 valid  output  1  one-cycle strobe when pulse_width/frame_len update.
REQ-011 range_err  output  1  last published pulse_width outside [MIN_PULSE, MAX_PULSE].
REQ-012 timeout  output  1  level; loss of signal detected.

Function
REQ-013 servo_in SHALL pass through a 2-flop synchronizer, then a registered edge detector producing one-cycle rise/fall.
REQ-014 FSM states SHALL be IDLE, HIGH and LOW.
REQ-015 IDLE: ignore everything until a rise; on rise go HIGH, clear counters to 1, no publish (partial frame discarded).
REQ-016 HIGH: high counter and frame counter increment each cycle; on fall, capture high count into a hold register and go LOW.
REQ-017 LOW: frame counter increments; on rise, publish hold register to pulse_width and frame counter to frame_len, restart counters at 1, go HIGH.
REQ-018 valid SHALL assert for exactly one cycle, the cycle after the synchronized rise that completes a frame; total latency from servo_in rising edge to valid SHALL be 4 clk cycles.
REQ-019 range_err SHALL update in the same cycle as valid and hold until the next publish.
REQ-020 High counter SHALL saturate at 1023, frame counter at 2047; no wrap-around.
REQ-021 If the frame counter reaches TIMEOUT_TICKS in HIGH or LOW, the block SHALL go IDLE, set timeout, and not assert valid.
REQ-022 timeout SHALL clear in the cycle valid next asserts; pulse_width/frame_len SHALL hold their last values while timeout is set.
REQ-023 A one-tick high glitch (after sync) SHALL be measured as pulse_width 1 and flagged range_err.
REQ-024 Rise and timeout in the same cycle: timeout SHALL win; transition to IDLE.
REQ-025 servo_in high when reset releases: block SHALL stay IDLE until a fall followed by a rise.

Reset
REQ-026 Asserting resetn low SHALL immediately force: state IDLE, synchronizer flops 0, counters 0, pulse_width 0, frame_len 0, valid 0, range_err 0, timeout 0.
REQ-027 Reset mid-frame SHALL discard the partial measurement; first publish after release requires two rises.

Structure
REQ-028 Package servo_pkg SHALL hold FRAME_TICKS, MIN_PULSE, MAX_PULSE, TIMEOUT_TICKS defaults, counter widths and the FSM state type, shared with the PWM generator.
REQ-029 Sub-module sync_edge_detect SHALL contain the 2-flop synchronizer and rise/fall detector; all else in servo_pulse_decoder.
REQ-030 Target size: 120-400 lines RTL total.

Verification
REQ-031 Drive frames of 1000 ticks with 50-tick pulses, 3 frames -> valid twice (from the second rise on), pulse_width 50, frame_len 1000, range_err 0.
REQ-032 Pulse width 20 then 130, frame 1000 -> range_err 1 on both publishes; 75 next -> range_err 0.
REQ-033 Stop input low after a frame for 2000 ticks -> timeout 1 at count 2000, no valid, outputs hold; restart 1000/50 frames -> first valid clears timeout.
REQ-034 Hold input high 2500 ticks -> timeout 1, state IDLE, no valid.
REQ-035 Assert resetn mid-HIGH, release with input high -> all outputs 0, no valid until fall, rise, full frame.
REQ-036 Check 4-cycle rise-to-valid latency and one-cycle valid width on every publish.
